vga_layer_mixer: RTL and testbench



---
 rtl/vga_layer_mixer.sv | 113 +++++++++++
 tb/tb_vga_layer_mixer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_mixer.sv
// rtl/vga_layer_mixer.sv - layered RGB compositor with frame-shadowed config and registered VGA drive
module vga_layer_mixer #(
  parameter int LAYERS  = 4,
  parameter int COLOR_W = 4,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int FRAME_W = 16
) (
  input  logic                          pclk,
  input  logic                          rst_n,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          hblnk_in,
  input  logic                          vblnk_in,
  input  logic [LAYERS*3*COLOR_W-1:0]   layer_rgb_in,
  input  logic [LAYERS-1:0]             layer_opaque_in,
  input  logic [LAYERS-1:0]             layer_en_cfg,
  input  logic [3*COLOR_W-1:0]          key_cfg,
  input  logic                          key_en_cfg,
  input  logic [3*COLOR_W-1:0]          bg_cfg,
  output logic                          hs,
  output logic                          vs,
  output logic [COLOR_W-1:0]            r,
  output logic [COLOR_W-1:0]            g,
  output logic [COLOR_W-1:0]            b,
  output logic                          frame_start,
  output logic [FRAME_W-1:0]            frame_cnt
);

  localparam int PIX_W = 3 * COLOR_W;

  logic                     s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;
  logic [LAYERS*PIX_W-1:0]  s1_rgb;
  logic [LAYERS-1:0]        s1_opaque;
  logic                     s1_vs_rise;
  logic                     armed;
  logic [LAYERS-1:0]        en_sh;
  logic [PIX_W-1:0]         key_sh, bg_sh;
  logic                     key_en_sh;
  logic                     vs_edge;
  logic [LAYERS-1:0]        vis;
  logic [PIX_W-1:0]         pix_sel;

  // armed suppresses a false edge when vsync is already high as reset releases
  assign vs_edge = armed & vsync_in & ~s1_vsync;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_rgb     <= '0;
      s1_opaque  <= '0;
      s1_vs_rise <= 1'b0;
      armed      <= 1'b0;
      en_sh      <= '1;
      key_sh     <= '0;
      key_en_sh  <= 1'b0;
      bg_sh      <= '0;
    end else begin
      s1_hsync   <= hsync_in;
      s1_vsync   <= vsync_in;
      s1_hblnk   <= hblnk_in;
      s1_vblnk   <= vblnk_in;
      s1_rgb     <= layer_rgb_in;
      s1_opaque  <= layer_opaque_in;
      s1_vs_rise <= vs_edge;
      armed      <= 1'b1;
      if (vs_edge) begin
        en_sh     <= layer_en_cfg;
        key_sh    <= key_cfg;
        key_en_sh <= key_en_cfg;
        bg_sh     <= bg_cfg;
      end
    end
  end

  for (genvar k = 0; k < LAYERS; k++) begin : g_vis
    assign vis[k] = en_sh[k] & s1_opaque[k] &
                    ~(key_en_sh & (s1_rgb[k*PIX_W +: PIX_W] == key_sh));
  end

  // Walk from the lowest priority upward so the lowest visible index wins.
  always_comb begin
    pix_sel = bg_sh;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (vis[k]) pix_sel = s1_rgb[k*PIX_W +: PIX_W];
    end
    if (s1_hblnk || s1_vblnk) pix_sel = '0;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hs          <= ~(s1_hsync ^ HS_POL);
      vs          <= ~(s1_vsync ^ VS_POL);
      r           <= pix_sel[3*COLOR_W-1:2*COLOR_W];
      g           <= pix_sel[2*COLOR_W-1:COLOR_W];
      b           <= pix_sel[COLOR_W-1:0];
      frame_start <= s1_vs_rise;
      if (s1_vs_rise) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb/tb_vga_layer_mixer.sv - scoreboard bench for vga_layer_mixer
module tb_vga_layer_mixer;

  localparam int LAYERS  = 4;
  localparam int COLOR_W = 4;
  localparam int FRAME_W = 2;
  localparam int PIX_W   = 3 * COLOR_W;

  logic                       pclk = 1'b0;
  logic                       rst_n;
  logic                       hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [LAYERS*PIX_W-1:0]    layer_rgb_in;
  logic [LAYERS-1:0]          layer_opaque_in, layer_en_cfg;
  logic [PIX_W-1:0]           key_cfg, bg_cfg;
  logic                       key_en_cfg;
  logic                       hs, vs, frame_start;
  logic [COLOR_W-1:0]         r, g, b;
  logic [FRAME_W-1:0]         frame_cnt;

  vga_layer_mixer #(
    .LAYERS(LAYERS), .COLOR_W(COLOR_W), .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_W(FRAME_W)
  ) dut (
    .pclk(pclk), .rst_n(rst_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .layer_rgb_in(layer_rgb_in), .layer_opaque_in(layer_opaque_in),
    .layer_en_cfg(layer_en_cfg), .key_cfg(key_cfg), .key_en_cfg(key_en_cfg), .bg_cfg(bg_cfg),
    .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] sb_q[$];

  // reference model state
  logic [LAYERS-1:0]  m_en;
  logic [PIX_W-1:0]   m_key, m_bg;
  logic               m_key_en, m_prev, m_armed;
  logic [FRAME_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = '1; m_key = '0; m_bg = '0; m_key_en = 1'b0;
    m_prev = 1'b0; m_armed = 1'b0; m_cnt = '0;
  endtask

  function automatic logic [31:0] dut_word();
    return 32'({hs, vs, r, g, b, frame_start, frame_cnt});
  endfunction

  task automatic step();
    logic             edge_v;
    logic [PIX_W-1:0] col, lrgb;
    edge_v = m_armed && vsync_in && !m_prev;
    if (edge_v) begin
      m_en = layer_en_cfg; m_key = key_cfg; m_key_en = key_en_cfg; m_bg = bg_cfg;
      m_cnt = m_cnt + 1'b1;
    end
    m_armed = 1'b1;
    m_prev  = vsync_in;
    col = m_bg;
    for (int k = 0; k < LAYERS; k++) begin
      lrgb = layer_rgb_in[k*PIX_W +: PIX_W];
      if (m_en[k] && layer_opaque_in[k] && !(m_key_en && lrgb == m_key)) begin
        col = lrgb;
        break;
      end
    end
    if (hblnk_in || vblnk_in) col = '0;
    sb_q.push_back(32'({~hsync_in, ~vsync_in, col, edge_v, m_cnt}));
    @(negedge pclk);
    if (sb_q.size() >= 2) check("pipe", dut_word(), sb_q.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic vsync_pulse();
    vblnk_in = 1'b1; run(2);
    vsync_in = 1'b1; run(3);
    vsync_in = 1'b0; run(2);
    vblnk_in = 1'b0;
  endtask

  function automatic logic [PIX_W-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return 12'hF00;
      1:       return 12'h0F0;
      2:       return 12'h00F;
      default: return 12'hF0F;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    layer_rgb_in = '0; layer_opaque_in = '0;
    layer_en_cfg = '1; key_cfg = '0; key_en_cfg = 0; bg_cfg = 12'h00F;
    model_reset();
    repeat (2) @(negedge pclk);
    check("rst_hs", 32'(hs), 32'd1);
    check("rst_vs", 32'(vs), 32'd1);
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;

    // priority, then background from shadowed bg_cfg
    vsync_pulse();
    layer_rgb_in = {12'h00F, 12'h0F0, 12'hF00, 12'h0FF};
    layer_opaque_in = 4'b0110;
    run(4);
    layer_opaque_in = 4'b0000;
    run(3);

    // colour key, mid-frame key change ignored
    key_cfg = 12'hF00; key_en_cfg = 1'b1;
    vsync_pulse();
    layer_opaque_in = 4'b0110;
    run(3);
    key_cfg = 12'h0F0;
    run(3);
    vsync_pulse();
    run(3);

    // blanking
    hblnk_in = 1'b1; run(3);
    hblnk_in = 1'b0; run(3);

    // 96-cycle hsync
    hsync_in = 1'b1; run(96);
    hsync_in = 1'b0; run(4);

    // disabled layer, random pixels with key hits
    layer_en_cfg = 4'b1101; key_cfg = 12'hF0F;
    vsync_pulse();
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < LAYERS; k++) layer_rgb_in[k*PIX_W +: PIX_W] = pick();
      layer_opaque_in = 4'($urandom_range(0, 15));
      hblnk_in = ($urandom_range(0, 7) == 0);
      step();
    end
    hblnk_in = 1'b0;

    // counter wrap (already 4 frames: wraps to 0, then 1, 2, 3)
    for (int i = 0; i < 3; i++) vsync_pulse();
    hsync_in = 1'b1; layer_opaque_in = 4'b0001;
    run(3);

    // asynchronous reset mid-line
    #2 rst_n = 1'b0;
    #1;
    check("arst_hs", 32'(hs), 32'd1);
    check("arst_vs", 32'(vs), 32'd1);
    check("arst_rgb", 32'({r, g, b}), 32'd0);
    check("arst_fs", 32'(frame_start), 32'd0);
    check("arst_cnt", 32'(frame_cnt), 32'd0);
    sb_q.delete();
    model_reset();
    hsync_in = 1'b0; vsync_in = 1'b1; vblnk_in = 1'b1;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    run(5);
    vsync_in = 1'b0; run(2);
    vsync_in = 1'b1; run(3);
    vsync_in = 1'b0; vblnk_in = 1'b0; run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
